uart_rx: RTL and testbench

- Serial receiver for the team's UART link; the receiving end of `uart_tx`.
- Frame format: line idles high, one low start bit, 8 data bits (MSB first by default), at least one high stop bit. `uart_tx` sends two stop bits; only the first is checked.
- Recovers each byte, presents it with a one-cycle valid strobe, and flags framing errors.
- Sits between the external serial pin and the byte-level consumer logic.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with 2-flop input synchronizer.
// Ports: clk, reset (async, high), rx in; data_out, valid, frame_err, busy out.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF =
    CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          smp;
  logic          take, bad;

  // cnt is 0 at t0 and runs modulo the bit time, so
  // every sample point lands on cnt == HALF.
  assign smp = (cnt == HALF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (!rx_s)
          state_n = smp ? DATA : START;
      START:
        if (smp)
          state_n = rx_s ? IDLE : DATA;
      DATA:
        if (smp && idx == 3'd7)
          state_n = STOP;
      STOP:
        if (smp)
          state_n = rx_s ? IDLE : BREAK;
      BREAK:
        if (rx_s)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n = '0;
    if (state_n != IDLE && state_n != BREAK)
      cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_comb begin
    idx_n = idx;
    sh_n  = sh;
    if (state == IDLE)
      idx_n = '0;
    if (state == DATA && smp) begin
      idx_n = idx + 3'd1;
      if (MSB_FIRST)
        sh_n = {sh[6:0], rx_s};
      else
        sh_n = {rx_s, sh[7:1]};
    end
  end

  always_comb begin
    busy = (state != IDLE);
    take = (state == STOP) && smp && rx_s;
    bad  = (state == STOP) && smp && !rx_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= take;
      frame_err <= bad;
      if (take)
        data_out <= sh;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 1 and 16 clocks/bit.
// Timing-formula model plus literal latency/data checks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxl [3];
  logic [7:0] dout [3];
  logic       vld [3];
  logic       ferr [3];
  logic       bsy [3];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .rx(rxl[0]),
    .data_out(dout[0]), .valid(vld[0]),
    .frame_err(ferr[0]), .busy(bsy[0])
  );

  uart_rx #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .rx(rxl[1]),
    .data_out(dout[1]), .valid(vld[1]),
    .frame_err(ferr[1]), .busy(bsy[1])
  );

  uart_rx #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .rx(rxl[2]),
    .data_out(dout[2]), .valid(vld[2]),
    .frame_err(ferr[2]), .busy(bsy[2])
  );

  int c_of [3]   = '{1, 16, 16};
  bit msb_of [3] = '{1'b1, 1'b1, 1'b0};

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit         h1 [3];
  bit         h2 [3];
  bit         m_in [3];
  bit         m_brk [3];
  int         m_t0 [3];
  logic [7:0] m_acc [3];
  logic [7:0] e_dat [3];
  bit         e_v [3];
  bit         e_f [3];
  bit         e_b [3];

  // monitor state
  int         vcnt [3] = '{0, 0, 0};
  int         vcyc [3] = '{0, 0, 0};
  int         fcnt [3] = '{0, 0, 0};
  int         fcyc [3] = '{0, 0, 0};
  int         rise [3] = '{0, 0, 0};
  int         fall [3] = '{0, 0, 0};
  logic [7:0] vlast [3];
  logic       pb [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] vq0 [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Sample points are t0+H+k*C for k=0 (start), 1..8 (data),
  // 9 (stop), where rs is the line value two edges back.
  task automatic step(input int d);
    bit rs;
    int c, hh, rel, k;
    c  = c_of[d];
    hh = (c - 1) / 2;
    if (reset) begin
      h1[d] = 1'b1; h2[d] = 1'b1;
      m_in[d] = 1'b0; m_brk[d] = 1'b0;
      m_acc[d] = 8'h00; e_dat[d] = 8'h00;
      e_v[d] = 1'b0; e_f[d] = 1'b0; e_b[d] = 1'b0;
      return;
    end
    rs = h2[d];
    h2[d] = h1[d];
    h1[d] = rxl[d];
    e_v[d] = 1'b0;
    e_f[d] = 1'b0;
    if (m_brk[d]) begin
      if (rs) m_brk[d] = 1'b0;
    end else begin
      if (!m_in[d] && !rs) begin
        m_in[d] = 1'b1;
        m_t0[d] = cyc;
      end
      if (m_in[d]) begin
        rel = cyc - m_t0[d] - hh;
        if (rel >= 0 && rel % c == 0) begin
          k = rel / c;
          if (k == 0) begin
            if (rs) m_in[d] = 1'b0;
          end else if (k <= 8) begin
            if (msb_of[d]) m_acc[d][8-k] = rs;
            else           m_acc[d][k-1] = rs;
          end else begin
            m_in[d] = 1'b0;
            if (rs) begin
              e_dat[d] = m_acc[d];
              e_v[d] = 1'b1;
            end else begin
              e_f[d] = 1'b1;
              m_brk[d] = 1'b1;
            end
          end
        end
      end
    end
    e_b[d] = m_in[d] | m_brk[d];
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) step(d);
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        chk($sformatf("rst_data%0d", d), dout[d], 8'h00);
        chk($sformatf("rst_valid%0d", d), vld[d], 1'b0);
        chk($sformatf("rst_ferr%0d", d), ferr[d], 1'b0);
        chk($sformatf("rst_busy%0d", d), bsy[d], 1'b0);
      end else begin
        chk($sformatf("data%0d", d), dout[d], e_dat[d]);
        chk($sformatf("valid%0d", d), vld[d], e_v[d]);
        chk($sformatf("ferr%0d", d), ferr[d], e_f[d]);
        chk($sformatf("busy%0d", d), bsy[d], e_b[d]);
      end
      if (vld[d] === 1'b1) begin
        vcnt[d]++;
        vcyc[d] = cyc;
        vlast[d] = dout[d];
        if (d == 0) vq0.push_back(dout[d]);
      end
      if (ferr[d] === 1'b1) begin
        fcnt[d]++;
        fcyc[d] = cyc;
      end
      if (bsy[d] !== pb[d]) begin
        if (bsy[d] === 1'b1) rise[d] = cyc;
        else                 fall[d] = cyc;
        pb[d] = bsy[d];
      end
    end
  end

  task automatic hold(input int d, input logic v, input int n);
    rxl[d] = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int d, input logic [7:0] b,
                       input int nstop, input logic stopv);
    int c;
    c = c_of[d];
    hold(d, 1'b0, c);
    for (int i = 0; i < 8; i++)
      hold(d, msb_of[d] ? b[7-i] : b[i], c);
    for (int s = 0; s < nstop; s++)
      hold(d, stopv, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, vb, fb;
    rxl[0] = 1'b1; rxl[1] = 1'b1; rxl[2] = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    hold(0, 1'b1, 4);

    // single frame, latency 12
    e = cyc;
    frame(0, 8'h52, 1, 1'b1);
    hold(0, 1'b1, 4);
    chk("t1_vcnt", vcnt[0], 1);
    chk("t1_data", vlast[0], 8'h52);
    chk("t1_latency", vcyc[0] - e, 12);
    chk("t1_busyfall", fall[0], vcyc[0]);
    chk("t1_ferr", fcnt[0], 0);

    // back-to-back: two stop bits, then single stop
    vq0.delete();
    frame(0, 8'hA5, 2, 1'b1);
    frame(0, 8'h00, 2, 1'b1);
    frame(0, 8'hFF, 2, 1'b1);
    frame(0, 8'h12, 1, 1'b1);
    frame(0, 8'h34, 1, 1'b1);
    hold(0, 1'b1, 6);
    chk("t2_count", vq0.size(), 5);
    if (vq0.size() == 5) begin
      chk("t2_b0", vq0[0], 8'hA5);
      chk("t2_b1", vq0[1], 8'h00);
      chk("t2_b2", vq0[2], 8'hFF);
      chk("t2_b3", vq0[3], 8'h12);
      chk("t2_b4", vq0[4], 8'h34);
    end
    chk("t2_ferr", fcnt[0], 0);

    // framing error then held-low break
    vb = vcnt[0];
    e = cyc;
    frame(0, 8'h3C, 1, 1'b0);
    hold(0, 1'b0, 20);
    r = cyc;
    hold(0, 1'b1, 8);
    chk("t3_fcnt", fcnt[0], 1);
    chk("t3_fcyc", fcyc[0] - e, 12);
    chk("t3_novalid", vcnt[0], vb);
    chk("t3_keep", dout[0], 8'h34);
    chk("t3_rise", rise[0] - e, 3);
    chk("t3_fall", fall[0] - r, 3);

    // start glitch at 16 clk/bit
    e = cyc;
    hold(1, 1'b0, 5);
    hold(1, 1'b1, 40);
    chk("t4_vcnt", vcnt[1], 0);
    chk("t4_fcnt", fcnt[1], 0);
    chk("t4_rise", rise[1] - e, 3);
    chk("t4_fall", fall[1] - e, 10);

    // good frame MSB first at 16 clk/bit
    e = cyc;
    frame(1, 8'hC3, 1, 1'b1);
    hold(1, 1'b1, 20);
    chk("t4b_data", vlast[1], 8'hC3);
    chk("t4b_cyc", vcyc[1] - e, 154);

    // LSB first at 16 clk/bit
    e = cyc;
    frame(2, 8'h81, 1, 1'b1);
    hold(2, 1'b1, 20);
    chk("t5_vcnt", vcnt[2], 1);
    chk("t5_data", vlast[2], 8'h81);
    chk("t5_cyc", vcyc[2] - e, 154);
    chk("t5_ferr", fcnt[2], 0);

    // reset during data bit 4 of 0x5A
    vb = vcnt[0];
    fb = fcnt[0];
    hold(0, 1'b0, 1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 1);
    rxl[0] = 1'b1;
    reset = 1'b1;
    hold(0, 1'b1, 3);
    reset = 1'b0;
    hold(0, 1'b1, 3);
    chk("t6_rstdata", dout[0], 8'h00);
    chk("t6_noout", vcnt[0], vb);
    frame(0, 8'h5A, 1, 1'b1);
    hold(0, 1'b1, 5);
    chk("t6_vcnt", vcnt[0], vb + 1);
    chk("t6_data", vlast[0], 8'h5A);
    chk("t6_ferr", fcnt[0], fb);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
